// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the 80x60 framebuffer rectangle-fill engine.
package vga_fb_pkg;

  localparam int FB_W = 80;
  localparam int FB_H = 60;

  localparam logic [31:0] OFF_XY    = 32'h0000_0000;
  localparam logic [31:0] OFF_WH    = 32'h0000_0004;
  localparam logic [31:0] OFF_COLOR = 32'h0000_0008;
  localparam logic [31:0] OFF_CTRL  = 32'h0000_000C;

  typedef struct packed {
    logic [5:0] y;
    logic [6:0] x;
  } fb_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FIN  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major pixel walker: latches the clipped rectangle bounds at load and
// steps one pixel per enabled cycle, flagging the final pixel.
module rect_scan_counter
  import vga_fb_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       load,
  input  logic       step,
  input  logic [6:0] x0,
  input  logic [5:0] y0,
  input  logic [6:0] xe,
  input  logic [5:0] ye,
  output fb_addr_t   addr,
  output logic       last
);

  logic [6:0] x0_r;
  logic [6:0] xe_r;
  logic [6:0] cx_r;
  logic [5:0] ye_r;
  logic [5:0] cy_r;

  // bounds capture and x/y stepping with wrap to x0 at the row end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x0_r <= 7'd0;
      xe_r <= 7'd0;
      ye_r <= 6'd0;
      cx_r <= 7'd0;
      cy_r <= 6'd0;
    end else if (load) begin
      x0_r <= x0;
      xe_r <= xe;
      ye_r <= ye;
      cx_r <= x0;
      cy_r <= y0;
    end else if (step) begin
      if (cx_r == xe_r) begin
        cx_r <= x0_r;
        cy_r <= cy_r + 6'd1;
      end else begin
        cx_r <= cx_r + 7'd1;
      end
    end
  end

  assign addr = {cy_r, cx_r};
  assign last = (cx_r == xe_r) && (cy_r == ye_r);

endmodule

// File: rtl/vga_rect_fill.sv
// IOBUS-mapped rectangle fill engine; arbitrates CPU single-pixel writes
// against the fill and drives the framebuffer write port with registered outputs.
module vga_rect_fill
  import vga_fb_pkg::*;
#(
  parameter logic [31:0] BASE_AD = 32'h11000180
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IO_ADDR,
  input  logic [31:0] IO_WDATA,
  input  logic        IO_WR,
  output logic [31:0] IO_RDATA,
  output logic        IO_RSEL,
  input  logic [12:0] PIX_WA,
  input  logic [7:0]  PIX_WD,
  input  logic        PIX_WE,
  output logic [12:0] FB_WA,
  output logic [7:0]  FB_WD,
  output logic        FB_WE,
  output logic        BUSY,
  output logic        DONE
);

  fsm_state_t state_r, state_s;
  logic wr_xy_s, wr_wh_s, wr_col_s, wr_ctrl_s, start_s, clr_s;
  logic [6:0] x0_r;
  logic [5:0] y0_r;
  logic [7:0] w_r;
  logic [6:0] h_r;
  logic [7:0] col_r;
  logic [7:0] col_wk_r;
  logic [8:0] x_sum_s, x_lim_s;
  logic [7:0] y_sum_s, y_lim_s;
  logic [6:0] xe_s;
  logic [5:0] ye_s;
  logic empty_s, load_s, step_s, last_s, drop_evt_s, drop_r;
  fb_addr_t scan_addr_s, fb_wa_s, fb_wa_r;
  logic [7:0] fb_wd_s, fb_wd_r;
  logic fb_we_s, fb_we_r, busy_s, busy_r, done_s, done_r;
  logic unused_wdata_s;

  assign wr_xy_s   = IO_WR && (IO_ADDR == BASE_AD + OFF_XY);
  assign wr_wh_s   = IO_WR && (IO_ADDR == BASE_AD + OFF_WH);
  assign wr_col_s  = IO_WR && (IO_ADDR == BASE_AD + OFF_COLOR);
  assign wr_ctrl_s = IO_WR && (IO_ADDR == BASE_AD + OFF_CTRL);
  assign start_s   = wr_ctrl_s && IO_WDATA[0];
  assign clr_s     = wr_ctrl_s && IO_WDATA[1];
  assign unused_wdata_s = ^IO_WDATA[31:15];

  assign IO_RSEL  = (IO_ADDR == BASE_AD + OFF_CTRL);
  assign IO_RDATA = IO_RSEL ? {30'd0, drop_r, busy_r} : 32'd0;

  // shadow configuration registers, writable at any time
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x0_r  <= 7'd0;
      y0_r  <= 6'd0;
      w_r   <= 8'd0;
      h_r   <= 7'd0;
      col_r <= 8'd0;
    end else begin
      if (wr_xy_s) begin
        x0_r <= IO_WDATA[6:0];
        y0_r <= IO_WDATA[13:8];
      end
      if (wr_wh_s) begin
        w_r <= IO_WDATA[7:0];
        h_r <= IO_WDATA[14:8];
      end
      if (wr_col_s) begin
        col_r <= IO_WDATA[7:0];
      end
    end
  end

  // clipped inclusive end coordinates; sums are widened so x0+w cannot wrap
  always_comb begin
    x_sum_s = {2'b00, x0_r} + {1'b0, w_r};
    y_sum_s = {2'b00, y0_r} + {1'b0, h_r};
    if (x_sum_s > 9'(FB_W)) begin
      x_lim_s = 9'(FB_W);
    end else begin
      x_lim_s = x_sum_s;
    end
    if (y_sum_s > 8'(FB_H)) begin
      y_lim_s = 8'(FB_H);
    end else begin
      y_lim_s = y_sum_s;
    end
    xe_s    = 7'(x_lim_s - 9'd1);
    ye_s    = 6'(y_lim_s - 8'd1);
    empty_s = (w_r == 8'd0) || (h_r == 7'd0) ||
              (x0_r >= 7'(FB_W)) || (y0_r >= 6'(FB_H));
  end

  assign load_s     = (state_r == ST_IDLE) && start_s && !empty_s;
  assign step_s     = (state_r == ST_FILL);
  assign drop_evt_s = PIX_WE && (state_r != ST_IDLE);

  rect_scan_counter u_scan (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (load_s),
    .step  (step_s),
    .x0    (x0_r),
    .y0    (y0_r),
    .xe    (xe_s),
    .ye    (ye_s),
    .addr  (scan_addr_s),
    .last  (last_s)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = empty_s ? ST_FIN : ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (last_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode feeding the output registers; CPU pixels pass only when idle
  always_comb begin
    fb_we_s = 1'b0;
    fb_wa_s = '0;
    fb_wd_s = 8'd0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (PIX_WE) begin
          fb_we_s = 1'b1;
          fb_wa_s = PIX_WA;
          fb_wd_s = PIX_WD;
        end else begin
          fb_we_s = 1'b0;
        end
      end
      ST_FILL: begin
        fb_we_s = 1'b1;
        fb_wa_s = scan_addr_s;
        fb_wd_s = col_wk_r;
        busy_s  = 1'b1;
      end
      ST_FIN:  done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // registered outputs, working colour and sticky drop flag (set beats clear)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fb_we_r  <= 1'b0;
      fb_wa_r  <= '0;
      fb_wd_r  <= 8'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      drop_r   <= 1'b0;
      col_wk_r <= 8'd0;
    end else begin
      fb_we_r <= fb_we_s;
      fb_wa_r <= fb_wa_s;
      fb_wd_r <= fb_wd_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      if (drop_evt_s) begin
        drop_r <= 1'b1;
      end else if (clr_s) begin
        drop_r <= 1'b0;
      end
      if (load_s) begin
        col_wk_r <= col_r;
      end
    end
  end

  assign FB_WE = fb_we_r;
  assign FB_WA = fb_wa_r;
  assign FB_WD = fb_wd_r;
  assign BUSY  = busy_r;
  assign DONE  = done_r;

endmodule
